// File: rtl/updown_ctrl_pkg.sv
// Shared types and constants for the up/down sweep controller that steers
// the 4-bit up/down counter through a bounded triangle.
package updown_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 4;
  localparam int SW_DEFAULT    = 8;
  localparam int MIN_SPAN      = 2;

  // A window needs room for at least one interior value, otherwise the
  // turn-early compares against hi-1 and lo+1 would fire immediately.
  function automatic logic span_ok(input int unsigned lo, input int unsigned hi);
    return (hi > lo) && ((hi - lo) >= MIN_SPAN);
  endfunction

endpackage

// File: rtl/updown_sweep_ctrl.sv
// Drives an external up/down counter's ud/reset inputs from its Q feedback so
// the count sweeps lo..hi..lo for a programmed number of triangles.
module updown_sweep_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SW    = SW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [SW-1:0]    cfg_sweeps,
  input  logic [WIDTH-1:0] q_in,
  output logic             ud,
  output logic             cnt_reset,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [SW-1:0]    sweep_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [SW-1:0]    sweeps_q, sweeps_d;
  logic [SW-1:0]    sweep_cnt_q, sweep_cnt_d;
  logic             ud_q, ud_d;
  logic             cnt_reset_q, cnt_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0] hi_m1;
  logic [WIDTH-1:0] lo_p1;
  logic [SW-1:0]    sweep_next;
  logic             cfg_valid;

  // Turning one count early lets ud flip on the same edge the counter lands
  // on the turnaround value, so it never overshoots.
  assign hi_m1      = hi_q - WIDTH'(1);
  assign lo_p1      = lo_q + WIDTH'(1);
  assign sweep_next = sweep_cnt_q + SW'(1);
  assign cfg_valid  = span_ok(32'(cfg_lo), 32'(cfg_hi));

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    ud_d        = ud_q;
    cnt_reset_d = cnt_reset_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    if (stop) begin
      state_d     = IDLE;
      ud_d        = 1'b1;
      cnt_reset_d = 1'b1;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ud_d        = 1'b1;
          cnt_reset_d = 1'b1;
          busy_d      = 1'b0;
          if (start) begin
            if (cfg_valid) begin
              lo_d        = cfg_lo;
              hi_d        = cfg_hi;
              sweeps_d    = cfg_sweeps;
              sweep_cnt_d = '0;
              cnt_reset_d = 1'b0;
              busy_d      = 1'b1;
              state_d     = UP;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        UP: begin
          if (q_in >= hi_m1) begin
            ud_d    = 1'b0;
            state_d = DOWN;
          end
        end
        DOWN: begin
          if (q_in <= lo_p1) begin
            sweep_cnt_d = sweep_next;
            if ((sweeps_q != '0) && (sweep_next == sweeps_q)) begin
              done_d      = 1'b1;
              cnt_reset_d = 1'b1;
              busy_d      = 1'b0;
              ud_d        = 1'b1;
              state_d     = IDLE;
            end else begin
              ud_d    = 1'b1;
              state_d = UP;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          ud_d        = 1'b1;
          cnt_reset_d = 1'b1;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      ud_q        <= 1'b1;
      cnt_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
      ud_q        <= ud_d;
      cnt_reset_q <= cnt_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign ud        = ud_q;
  assign cnt_reset = cnt_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench: the sweep controller closed-loop with a behavioural model of
// the 4-bit up/down counter (synchronous reset, +1 when ud, -1 otherwise).
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] cfg_lo;
  logic [3:0] cfg_hi;
  logic [7:0] cfg_sweeps;
  logic [3:0] q;
  logic       ud;
  logic       cnt_reset;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [7:0] sweep_cnt;

  int vec_count  = 0;
  int miscompares = 0;

  updown_sweep_ctrl #(.WIDTH(4), .SW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .cfg_sweeps (cfg_sweeps),
    .q_in       (q),
    .ud         (ud),
    .cnt_reset  (cnt_reset),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .sweep_cnt  (sweep_cnt)
  );

  always #5 clk = ~clk;

  // Downstream counter being steered.
  always @(posedge clk) begin
    if (cnt_reset) q <= 4'd0;
    else if (ud)   q <= q + 4'd1;
    else           q <= q - 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] lo, input logic [3:0] hi,
                               input logic [7:0] sweeps, input logic st, input logic sp);
    cfg_lo     = lo;
    cfg_hi     = hi;
    cfg_sweeps = sweeps;
    start      = st;
    stop       = sp;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  int exp_q1 [17] = '{0,1,2,3,4,5,6,5,4,3,4,5,6,5,4,3,0};
  int exp_ud1[17] = '{1,1,1,1,1,1,0,0,0,1,1,1,0,0,0,1,1};
  int exp_q5 [11] = '{0,1,2,3,4,5,6,5,4,3,0};
  int bad_lo [3]  = '{5,9,7};
  int bad_hi [3]  = '{6,4,7};

  initial begin
    reset = 1'b1;
    applyStimulus(4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_ud",        32'(ud),        32'd1);
    checkOutput("rst_cnt_reset", 32'(cnt_reset), 32'd1);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_done",      32'(done),      32'd0);
    checkOutput("rst_cfg_err",   32'(cfg_err),   32'd0);
    checkOutput("rst_sweep_cnt", 32'(sweep_cnt), 32'd0);
    checkOutput("rst_q",         32'(q),         32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] lo=3 hi=6 sweeps=2, with a stray start mid-sweep");
    applyStimulus(4'd3, 4'd6, 8'd2, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 17; i++) begin
      checkOutput($sformatf("t1_q[%0d]", i),    32'(q),    32'(exp_q1[i]));
      checkOutput($sformatf("t1_done[%0d]", i), 32'(done), (i == 15) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t1_ud[%0d]", i),   32'(ud),   32'(exp_ud1[i]));
      checkOutput($sformatf("t1_busy[%0d]", i), 32'(busy), (i < 15) ? 32'd1 : 32'd0);
      if (i == 9)  checkOutput("t1_sweep_cnt_first", 32'(sweep_cnt), 32'd1);
      if (i == 4)  applyStimulus(4'd0, 4'd15, 8'd0, 1'b1, 1'b0);
      else         applyStimulus(4'd3, 4'd6, 8'd2, 1'b0, 1'b0);
      tick();
    end
    checkOutput("t1_sweep_cnt_end", 32'(sweep_cnt), 32'd2);
    checkOutput("t1_cnt_reset_end", 32'(cnt_reset), 32'd1);

    $display("[TB] rejected configurations");
    for (int j = 0; j < 3; j++) begin
      applyStimulus(4'(bad_lo[j]), 4'(bad_hi[j]), 8'd1, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("cfg_err_pulse[%0d]", j), 32'(cfg_err), 32'd1);
      checkOutput($sformatf("cfg_err_busy[%0d]", j),  32'(busy),    32'd0);
      applyStimulus(4'(bad_lo[j]), 4'(bad_hi[j]), 8'd1, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("cfg_err_clear[%0d]", j), 32'(cfg_err),   32'd0);
      checkOutput($sformatf("cfg_err_q[%0d]", j),     32'(q),         32'd0);
      checkOutput($sformatf("cfg_err_park[%0d]", j),  32'(cnt_reset), 32'd1);
    end

    $display("[TB] start and stop together in IDLE");
    applyStimulus(4'd3, 4'd6, 8'd2, 1'b1, 1'b1);
    tick();
    checkOutput("ss_busy",      32'(busy),      32'd0);
    checkOutput("ss_cnt_reset", 32'(cnt_reset), 32'd1);
    checkOutput("ss_cfg_err",   32'(cfg_err),   32'd0);
    checkOutput("ss_sweep_cnt", 32'(sweep_cnt), 32'd2);
    applyStimulus(4'd3, 4'd6, 8'd2, 1'b0, 1'b0);
    tick();
    checkOutput("ss_q", 32'(q), 32'd0);

    $display("[TB] full range free-running sweep");
    applyStimulus(4'd0, 4'd15, 8'd0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 100; k++) begin
      int m;
      m = k % 30;
      applyStimulus(4'd0, 4'd15, 8'd0, 1'b0, 1'b0);
      checkOutput($sformatf("fr_q[%0d]", k),   32'(q),         (m <= 15) ? 32'(m) : 32'(30 - m));
      checkOutput($sformatf("fr_cnt[%0d]", k), 32'(sweep_cnt), 32'(k / 30));
      checkOutput($sformatf("fr_done[%0d]", k), 32'(done),     32'd0);
      if (k < 99) tick();
    end
    applyStimulus(4'd0, 4'd15, 8'd0, 1'b0, 1'b1);
    tick();
    checkOutput("fr_stop_busy", 32'(busy),      32'd0);
    checkOutput("fr_stop_cnt",  32'(sweep_cnt), 32'd3);
    checkOutput("fr_stop_q",    32'(q),         32'd10);
    applyStimulus(4'd0, 4'd15, 8'd0, 1'b0, 1'b0);
    tick();
    checkOutput("fr_stop_park", 32'(q), 32'd0);

    $display("[TB] stop while descending at Q=7");
    applyStimulus(4'd2, 4'd10, 8'd0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 14; k++) begin
      applyStimulus(4'd2, 4'd10, 8'd0, 1'b0, 1'b0);
      checkOutput($sformatf("st_q[%0d]", k), 32'(q), (k <= 10) ? 32'(k) : 32'(20 - k));
      if (k < 13) tick();
    end
    applyStimulus(4'd2, 4'd10, 8'd0, 1'b0, 1'b1);
    tick();
    checkOutput("st_cnt_reset", 32'(cnt_reset), 32'd1);
    checkOutput("st_busy",      32'(busy),      32'd0);
    checkOutput("st_done",      32'(done),      32'd0);
    checkOutput("st_ud",        32'(ud),        32'd1);
    checkOutput("st_q_edge",    32'(q),         32'd6);
    applyStimulus(4'd2, 4'd10, 8'd0, 1'b0, 1'b0);
    tick();
    checkOutput("st_q_park", 32'(q), 32'd0);

    $display("[TB] synchronous reset while ramping up");
    applyStimulus(4'd3, 4'd6, 8'd1, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'd3, 4'd6, 8'd1, 1'b0, 1'b0);
      checkOutput($sformatf("rs_q[%0d]", k), 32'(q), 32'(k));
      if (k < 4) tick();
    end
    reset = 1'b1;
    tick();
    checkOutput("rs_ud",        32'(ud),        32'd1);
    checkOutput("rs_cnt_reset", 32'(cnt_reset), 32'd1);
    checkOutput("rs_busy",      32'(busy),      32'd0);
    checkOutput("rs_done",      32'(done),      32'd0);
    checkOutput("rs_cfg_err",   32'(cfg_err),   32'd0);
    checkOutput("rs_sweep_cnt", 32'(sweep_cnt), 32'd0);
    checkOutput("rs_q_edge",    32'(q),         32'd5);
    tick();
    checkOutput("rs_q_park", 32'(q), 32'd0);
    reset = 1'b0;
    tick();
    applyStimulus(4'd3, 4'd6, 8'd1, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 11; k++) begin
      applyStimulus(4'd3, 4'd6, 8'd1, 1'b0, 1'b0);
      checkOutput($sformatf("rs2_q[%0d]", k),    32'(q),    32'(exp_q5[k]));
      checkOutput($sformatf("rs2_done[%0d]", k), 32'(done), (k == 9) ? 32'd1 : 32'd0);
      if (k < 10) tick();
    end
    checkOutput("rs2_sweep_cnt", 32'(sweep_cnt), 32'd1);
    checkOutput("rs2_busy",      32'(busy),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Upstream controller for the 4-bit up/down counter. It drives the counter's ud and reset inputs and watches the counter's Q output as feedback. The result is a bounded triangle sweep: the count ramps up to cfg_hi, back down to cfg_lo, and repeats for a programmed number of sweeps. While idle it parks the counter at 0 by holding the counter in reset.

Parameters:
- WIDTH, 4, counter width; must match the downstream counter's Q.
- SW, 8, width of the sweep-count configuration and of the sweep_cnt status.

Ports:
- clk, input, 1, system clock; all logic rises on the posedge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, one-cycle request; honoured only in IDLE.
- stop, input, 1, abort; highest priority in every state.
- cfg_lo, input, WIDTH, lower turnaround value; latched on an accepted start.
- cfg_hi, input, WIDTH, upper turnaround value; latched on an accepted start.
- cfg_sweeps, input, SW, number of full triangles; 0 means run until stop.
- q_in, input, WIDTH, feedback from the counter's Q.
- ud, output, 1, direction to the counter: 1 = up, 0 = down. Registered.
- cnt_reset, output, 1, drives the counter's reset input. Registered.
- busy, output, 1, high in UP or DOWN.
- done, output, 1, one-cycle pulse when the programmed sweeps complete.
- cfg_err, output, 1, one-cycle pulse when a start is rejected.
- sweep_cnt, output, SW, number of completed triangles in the current run.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - ud = 1, cnt_reset = 1
  - busy = 0, done = 0, cfg_err = 0
  - sweep_cnt = 0
  - latched lo, hi and sweeps = 0
- All outputs are registered. done and cfg_err default to 0 every cycle unless set.
- States: IDLE, UP, DOWN.
- IDLE:
  - cnt_reset = 1 and ud = 1, so the counter is held at 0.
  - start with cfg_hi − cfg_lo ≥ 2 (unsigned, cfg_hi > cfg_lo): latch the config, clear sweep_cnt, set cnt_reset = 0, busy = 1, go to UP.
  - start with invalid config: pulse cfg_err, stay in IDLE, latched values unchanged.
- UP (ud = 1):
  - When q_in ≥ hi−1: set ud = 0 and go to DOWN.
  - The counter lands exactly on hi and turns with no overshoot.
  - The initial ramp from 0 passes through lo without action.
- DOWN (ud = 0):
  - When q_in ≤ lo+1: the counter lands on lo and one triangle completes; sweep_cnt increments.
  - If sweeps ≠ 0 and the incremented sweep_cnt equals sweeps: pulse done, go to IDLE (cnt_reset = 1, busy = 0, ud = 1).
  - Otherwise: set ud = 1 and go to UP.
- stop, in any state: go to IDLE on the next edge with the IDLE output values. No done pulse. sweep_cnt holds its value.
- start while busy is ignored.
- start and stop in the same cycle: stop wins.
- The ≥ and ≤ comparisons are deliberate. If q_in is corrupted outside the window, the controller turns at once instead of wrapping.
- sweep_cnt wraps modulo 2^SW when sweeps = 0.
- reset mid-sweep returns everything to reset values on that edge. The counter is re-parked by cnt_reset = 1.
- Latency:
  - ud changes on the same edge at which the counter reaches hi or lo.
  - The counter's first increment after an accepted start occurs on the second edge after start is sampled.

Decomposition:
- Package updown_ctrl_pkg holds:
  - the state enum {IDLE, UP, DOWN}
  - localparam defaults for WIDTH and SW
  - localparam MIN_SPAN = 2
- A single module, no sub-module. The window compare and sweep counter are small enough to stay inline.
- The bench instantiates updown_sweep_ctrl together with the existing counter: q_in wired to Q, ud to ud, cnt_reset to the counter's reset.

Test Plan:
- lo=3, hi=6, sweeps=2, start. Required responses:
  - Counter Q after start: 0,1,2,3,4,5,6,5,4,3,4,5,6,5,4,3, then 0.
  - done pulses once, in the cycle after the second landing on 3.
  - sweep_cnt = 2; busy then 0.
- lo=5, hi=6, start → cfg_err pulses for 1 cycle, busy stays 0, Q stays 0. Repeat with lo=9, hi=4 and with lo=hi=7: same response.
- lo=0, hi=15, sweeps=0, run 100 cycles → Q never exceeds 15 or goes below 0 (no 4-bit wrap). sweep_cnt increments once per 30-cycle triangle.
- lo=2, hi=10, stop asserted while Q=7 in DOWN → next edge cnt_reset = 1, busy = 0, no done; Q = 0 one edge later.
- start pulsed again mid-sweep → ignored, sweep sequence unchanged. start and stop in the same IDLE cycle → stays IDLE.
- Synchronous reset asserted while in UP at Q=4 → all outputs at reset values on that edge; a new start after reset deasserts sweeps normally from 0.
